// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: round-robin two-requester issue/sequencing controller for the mor1kx FPU.
// Optional FPU_ISSUE_WDOG_EN adds a WAIT/DRAIN watchdog with a sticky err flag.
module fpu_issue_ctrl #(
  parameter int OP_W     = 8,
  parameter int RM_W     = 2,
  parameter int CSR_W    = 12,
  parameter int CMP_BIT  = 3,
  parameter int WDOG_MAX = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_opa,
  input  logic [31:0]      req0_opb,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [RM_W-1:0]  req0_rm,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_opa,
  input  logic [31:0]      req1_opb,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [RM_W-1:0]  req1_rm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_cmp,
  output logic [CSR_W-1:0] rsp_flags,
  output logic             fpu_flush,
  output logic             fpu_decode,
  output logic             fpu_execute,
  output logic [OP_W-1:0]  fpu_op,
  output logic [RM_W-1:0]  fpu_rm,
  output logic [31:0]      fpu_opa,
  output logic [31:0]      fpu_opb,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_valid_arith,
  input  logic             fpu_cmp,
  input  logic             fpu_valid_cmp,
  input  logic [CSR_W-1:0] fpu_fpcsr,
  output logic             busy,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WAIT, RESP, FLUSH, DRAIN} state_t;
  state_t            state_q, state_d;
  logic              prio_q, prio_d, id_q, id_d, cmp_q, cmp_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RM_W-1:0]   rm_q, rm_d;
  logic [31:0]       opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CSR_W-1:0]  flags_q, flags_d;
  logic              gnt0, gnt1, fire, drained, wdog_wait, wdog_drain;
  // prio_q=1 means req1 wins a tie; every grant hands priority to the other side
  assign gnt0 = state_q == IDLE && req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = state_q == IDLE && req1_valid && (!req0_valid || prio_q);
  assign fire = op_q[CMP_BIT] ? fpu_valid_cmp : fpu_valid_arith;
  assign drained = fpu_out == '0 && !fpu_valid_arith && !fpu_valid_cmp;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_cmp = cmp_q;
  assign rsp_flags = flags_q;
  assign fpu_decode = state_q == DECODE;
  assign fpu_execute = state_q == EXEC;
  assign fpu_flush = state_q == FLUSH;
  assign fpu_op = op_q;
  assign fpu_rm = rm_q;
  assign fpu_opa = opa_q;
  assign fpu_opb = opb_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    id_d = id_q;
    op_d = op_q;
    rm_d = rm_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    cmp_d = cmp_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        state_d = DECODE;
        id_d = gnt1;
        prio_d = !gnt1;
        op_d = gnt1 ? req1_op : req0_op;
        rm_d = gnt1 ? req1_rm : req0_rm;
        opa_d = gnt1 ? req1_opa : req0_opa;
        opb_d = gnt1 ? req1_opb : req0_opb;
      end
      DECODE: state_d = EXEC;
      EXEC: state_d = WAIT;
      WAIT: if (fire) begin
        state_d = RESP;
        res_d = fpu_out;
        cmp_d = fpu_cmp;
        flags_d = fpu_fpcsr;
      end else if (wdog_wait) begin
        state_d = RESP;
        res_d = '1;
        cmp_d = 1'b0;
        flags_d = '0;
      end
      RESP: state_d = rsp_ready ? FLUSH : RESP;
      FLUSH: state_d = DRAIN;
      DRAIN: state_d = (drained || wdog_drain) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      id_q <= 1'b0;
      op_q <= '0;
      rm_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      cmp_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      id_q <= id_d;
      op_q <= op_d;
      rm_q <= rm_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      cmp_q <= cmp_d;
      flags_q <= flags_d;
    end
  end
`ifdef FPU_ISSUE_WDOG_EN
  localparam int CW = $clog2(WDOG_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  // counter restarts on every state change and only advances while waiting on the FPU
  assign wdog_wait = state_q == WAIT && cnt_q == CW'(WDOG_MAX - 1);
  assign wdog_drain = state_q == DRAIN && cnt_q == CW'(WDOG_MAX - 1);
  assign err = err_q;
  always_comb begin
    cnt_d = state_d != state_q ? '0 : (state_q == WAIT || state_q == DRAIN) ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q || wdog_wait || wdog_drain;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign wdog_wait = 1'b0;
  assign wdog_drain = 1'b0;
  // always false; keeps WDOG_MAX referenced when the watchdog is compiled out
  assign err = WDOG_MAX < 0;
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench with a reactive FPU stand-in and a per-cycle transaction-level model.
module tb_fpu_issue_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_opa = 0, req0_opb = 0, req1_opa = 0, req1_opb = 0;
  logic [7:0]  req0_op = 0, req1_op = 0, fpu_op;
  logic [1:0]  req0_rm = 0, req1_rm = 0, fpu_rm;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cmp;
  logic [31:0] rsp_result, fpu_opa, fpu_opb, fpu_out = 0;
  logic [11:0] rsp_flags, fpu_fpcsr = 0;
  logic        fpu_flush, fpu_decode, fpu_execute, fpu_valid_arith = 0, fpu_cmp = 0, fpu_valid_cmp = 0;
  logic        busy, err;
  int          checks = 0, errors = 0;
  int          fpu_lat = 2;
  bit          stall = 0;

  fpu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req0_op(req0_op), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb),
    .req1_op(req1_op), .req1_rm(req1_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cmp(rsp_cmp), .rsp_flags(rsp_flags),
    .fpu_flush(fpu_flush), .fpu_decode(fpu_decode), .fpu_execute(fpu_execute),
    .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_out(fpu_out), .fpu_valid_arith(fpu_valid_arith), .fpu_cmp(fpu_cmp),
    .fpu_valid_cmp(fpu_valid_cmp), .fpu_fpcsr(fpu_fpcsr), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fres(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == 8'd0 && a == 32'h3F800000 && b == 32'h3F800000) ? 32'h40000000 : a + b;
  endfunction

  // FPU stand-in: result after fpu_lat cycles, a wrong-class valid pulse just before,
  // and fpu_out lingering two cycles past flush so DRAIN has to wait
  initial begin
    bit pend = 0;
    int cnt = 0, dcnt = 0;
    logic [7:0] op;
    logic [31:0] a, b;
    forever begin
      @(posedge clk); #2;
      fpu_valid_arith = 0;
      fpu_valid_cmp = 0;
      if (!reset_n) begin
        pend = 0; dcnt = 0; fpu_out = 0; fpu_cmp = 0; fpu_fpcsr = 0;
      end else begin
        if (fpu_execute) begin
          pend = 1; cnt = fpu_lat; op = fpu_op; a = fpu_opa; b = fpu_opb;
        end else if (pend && !stall) begin
          if (cnt == 0) begin
            pend = 0;
            fpu_fpcsr = {4'h0, op};
            if (op[3]) begin
              fpu_cmp = (a == b);
              fpu_out = {31'b0, a == b};
              fpu_valid_cmp = 1;
            end else begin
              fpu_cmp = 0;
              fpu_out = fres(op, a, b);
              fpu_valid_arith = 1;
            end
          end else begin
            if (cnt == 1) begin
              if (op[3]) begin fpu_valid_arith = 1; fpu_out = 32'hBAD0BAD0; end
              else begin fpu_valid_cmp = 1; fpu_cmp = 1; end
            end
            cnt--;
          end
        end
        if (fpu_flush) begin
          dcnt = 2; pend = 0;
        end else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin fpu_out = 0; fpu_cmp = 0; fpu_fpcsr = 0; end
        end
      end
    end
  end

  // Transaction model: phase 0 idle, 1 decode, 2 execute, 3 awaiting result,
  // 4 response offered, 5 flush, 6 draining; checked every cycle
  initial begin
    int ph = 0, wcnt = 0;
    bit rr = 0, mid = 0, eerr = 0, ecmp = 0, g0, g1;
    logic [7:0] mop = 0;
    logic [1:0] mrm = 0;
    logic [31:0] mopa = 0, mopb = 0, eres = 0;
    logic [11:0] eflags = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g0 = ph == 0 && req0_valid && (!req1_valid || !rr);
      g1 = ph == 0 && req1_valid && (!req0_valid || rr);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("busy", busy, ph != 0);
      chk("fpu_decode", fpu_decode, ph == 1);
      chk("fpu_execute", fpu_execute, ph == 2);
      chk("fpu_flush", fpu_flush, ph == 5);
      chk("rsp_valid", rsp_valid, ph == 4);
      chk("err", err, eerr);
      if (ph != 0) begin
        chk("fpu_op", fpu_op, mop);
        chk("fpu_rm", fpu_rm, mrm);
        chk("fpu_opa", fpu_opa, mopa);
        chk("fpu_opb", fpu_opb, mopb);
      end
      if (ph == 4) begin
        chk("rsp_id", rsp_id, mid);
        chk("rsp_result", rsp_result, eres);
        chk("rsp_cmp", rsp_cmp, ecmp);
        chk("rsp_flags", rsp_flags, eflags);
      end
      if (!reset_n) begin
        ph = 0; rr = 0; wcnt = 0; eerr = 0;
      end else case (ph)
        0: if (g0 || g1) begin
          mid = g1; rr = !g1; ph = 1;
          mop = g1 ? req1_op : req0_op;
          mrm = g1 ? req1_rm : req0_rm;
          mopa = g1 ? req1_opa : req0_opa;
          mopb = g1 ? req1_opb : req0_opb;
        end
        1: ph = 2;
        2: begin ph = 3; wcnt = 0; end
        3: if (mop[3] ? fpu_valid_cmp : fpu_valid_arith) begin
          eres = fpu_out; ecmp = fpu_cmp; eflags = fpu_fpcsr; ph = 4;
        end
`ifdef FPU_ISSUE_WDOG_EN
        else if (wcnt == 63) begin
          eres = 32'hFFFFFFFF; ecmp = 0; eflags = 0; eerr = 1; ph = 4;
        end else wcnt++;
`endif
        4: if (rsp_ready) ph = 5;
        5: begin ph = 6; wcnt = 0; end
        6: if (fpu_out == 0 && !fpu_valid_arith && !fpu_valid_cmp) ph = 0;
`ifdef FPU_ISSUE_WDOG_EN
        else if (wcnt == 63) begin eerr = 1; ph = 0; end else wcnt++;
`endif
        default: ph = 0;
      endcase
    end
  end

  task automatic issue(input bit r, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rm);
    bit got = 0;
    @(posedge clk); #1;
    if (r) begin req1_op = op; req1_opa = a; req1_opb = b; req1_rm = rm; req1_valid = 1; end
    else begin req0_op = op; req0_opa = a; req0_opb = b; req0_rm = rm; req0_valid = 1; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = r ? req1_ready : req0_ready;
    end
    chk("accept_seen", got, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_seen", busy, 0);
  endtask

  initial begin
    logic [31:0] held;
    int gseq[$];
    int n1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fpu_opa", fpu_opa, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    reset_n = 1;

    // 1.0 + 1.0 from req0
    issue(0, 8'd0, 32'h3F800000, 32'h3F800000, 2'd0);
    @(negedge clk); chk("t1_decode", fpu_decode, 1);
    @(negedge clk); chk("t1_execute", fpu_execute, 1); chk("t1_decode_low", fpu_decode, 0);
    wait_rsp();
    chk("t1_result", rsp_result, 32'h40000000);
    chk("t1_id", rsp_id, 0);
    @(negedge clk); chk("t1_flush", fpu_flush, 1);
    @(negedge clk); chk("t1_flush_once", fpu_flush, 0);
    wait_idle();

    // compare-equal from req1
    issue(1, 8'd8, 32'h40400000, 32'h40400000, 2'd1);
    wait_rsp();
    chk("t2_cmp", rsp_cmp, 1);
    chk("t2_id", rsp_id, 1);
    chk("t2_flags", rsp_flags, 12'h008);
    wait_idle();

    // both requesters persistently valid
    @(posedge clk); #1;
    req0_op = 8'd0; req0_opa = 32'h3F800000; req0_opb = 32'h3F800000; req0_rm = 2'd0;
    req1_op = 8'd8; req1_opa = 32'h1; req1_opb = 32'h1; req1_rm = 2'd3;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 400 && gseq.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) gseq.push_back(0);
      if (req1_ready) gseq.push_back(1);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("t3_grants", gseq.size(), 4);
    while (gseq.size() < 4) gseq.push_back(-1);
    chk("t3_g0", gseq[0], 0);
    chk("t3_g1", gseq[1], 1);
    chk("t3_g2", gseq[2], 0);
    chk("t3_g3", gseq[3], 1);
    wait_idle();

    // req1 raises and drops valid while an op is in flight
    issue(0, 8'd2, 32'h10, 32'h20, 2'd2);
    @(posedge clk); #1; req1_valid = 1;
    n1 = 0;
    repeat (2) begin @(negedge clk); n1 += req1_ready; end
    @(posedge clk); #1; req1_valid = 0;
    chk("t3b_no_grant", n1, 0);
    wait_rsp();
    chk("t3b_result", rsp_result, 32'h30);
    wait_idle();

    // response back-pressure
    @(posedge clk); #1; rsp_ready = 0;
    issue(1, 8'd1, 32'h40000000, 32'h3F800000, 2'd0);
    wait_rsp();
    held = rsp_result;
    chk("t4_result", held, 32'h7F800000);
    repeat (10) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_result", rsp_result, held);
      chk("t4_no_flush", fpu_flush, 0);
    end
    @(posedge clk); #1; rsp_ready = 1;
    @(negedge clk); chk("t4_flush_wait", fpu_flush, 0);
    @(negedge clk); chk("t4_flush", fpu_flush, 1);
    wait_idle();

    // reset while waiting on the FPU
    fpu_lat = 6;
    issue(0, 8'd0, 32'h3F800000, 32'h3F800000, 2'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; reset_n = 0;
    @(posedge clk); #1; reset_n = 1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_fpu_opa", fpu_opa, 0);
    chk("t5_fpu_op", fpu_op, 0);
    chk("t5_rsp_result", rsp_result, 0);
    n1 = 0;
    repeat (12) begin @(negedge clk); n1 += rsp_valid; end
    chk("t5_no_rsp", n1, 0);
    fpu_lat = 2;
    issue(1, 8'd8, 32'h1, 32'h2, 2'd0);
    wait_rsp();
    chk("t5_id", rsp_id, 1);
    chk("t5_cmp", rsp_cmp, 0);
    wait_idle();

`ifdef FPU_ISSUE_WDOG_EN
    // stalled FPU trips the watchdog
    stall = 1;
    issue(0, 8'd0, 32'h3F800000, 32'h3F800000, 2'd0);
    n1 = 0;
    for (int i = 0; i < 200 && !rsp_valid; i++) begin @(negedge clk); n1++; end
    chk("t6_latency", n1, 67);
    chk("t6_err", err, 1);
    chk("t6_result", rsp_result, 32'hFFFFFFFF);
    chk("t6_flags", rsp_flags, 0);
    stall = 0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencing and arbitration controller in front of the mor1kx FPU.
- Accepts operation requests from two independent requesters and arbitrates between them round-robin.
- Drives the FPU decode/execute/flush protocol, captures the arithmetic or compare result, and returns it with the requester ID.
- Lets multiple agents (stimulus threads, future core ports) share one FPU instance without overlapping operations.

Parameters:
OP_W, 8, FPU opcode width (matches OR1K_FPUOP_WIDTH)
RM_W, 2, rounding-mode width (matches OR1K_FPCSR_RM_SIZE)
CSR_W, 12, FPCSR flag width (matches OR1K_FPCSR_WIDTH)
CMP_BIT, 3, opcode bit that marks a compare operation
WDOG_MAX, 64, watchdog limit in cycles (used only with FPU_ISSUE_WDOG_EN)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
req0_valid / req1_valid  in  1  requester has an operation pending
req0_ready / req1_ready  out  1  operation accepted this cycle
req0_opa, req0_opb / req1_opa, req1_opb  in  32  operands
req0_op / req1_op  in  OP_W  FPU opcode
req0_rm / req1_rm  in  RM_W  rounding mode
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that issued the operation
rsp_result  out  32  captured fpuOut
rsp_cmp  out  1  captured compare flag
rsp_flags  out  CSR_W  captured fpcsr
fpu_flush, fpu_decode, fpu_execute  out  1  FPU control strobes
fpu_op  out  OP_W  opcode to FPU
fpu_rm  out  RM_W  rounding mode to FPU
fpu_opa, fpu_opb  out  32  operands to FPU
fpu_out  in  32  FPU result
fpu_valid_arith  in  1  arithmetic result valid
fpu_cmp  in  1  compare result
fpu_valid_cmp  in  1  compare result valid
busy  out  1  high in every state except IDLE
err  out  1  sticky watchdog error (feature-dependent)

Behaviour:
- Reset: synchronous on reset_n=0; all outputs 0 and state IDLE. The round-robin pointer prefers req0 after reset. Reset mid-operation aborts in the same edge; any captured response is discarded.
- Arbitration (IDLE only):
  - Only one valid requester: grant it.
  - Both valid: grant the requester not granted last, then update the pointer.
  - reqN_ready is a one-cycle pulse in IDLE for the granted requester only (combinational from valid and pointer).
  - Operands, opcode, rm and ID are latched on acceptance and driven on fpu_* until DRAIN completes.
- States:
  - IDLE -> DECODE on acceptance.
  - DECODE: fpu_decode=1 for 1 cycle -> EXEC.
  - EXEC: fpu_execute=1 for 1 cycle, fpu_decode=0 -> WAIT.
  - WAIT: all strobes 0. If op[CMP_BIT]=1, wait for fpu_valid_cmp; otherwise wait for fpu_valid_arith. On the valid cycle, capture fpu_out, fpu_cmp and fpu_fpcsr -> RESP.
  - RESP: rsp_valid=1, rsp_* held stable until rsp_valid&&rsp_ready -> FLUSH.
  - FLUSH: fpu_flush=1 for 1 cycle -> DRAIN.
  - DRAIN: wait until fpu_out==0, fpu_valid_arith==0 and fpu_valid_cmp==0 in the same cycle -> IDLE.
- Latency: acceptance at cycle T; decode at T+1; execute at T+2; earliest rsp_valid at V+1, where V is the FPU valid cycle.
- Boundary conditions:
  - No new request is accepted until the FSM is back in IDLE (one operation in flight).
  - A valid for the wrong class in WAIT (e.g. valid_arith during a compare) is ignored.
  - A requester may deassert valid before acceptance; no grant is then issued.
  - Back-to-back: one idle cycle minimum between DRAIN exit and the next acceptance.

Optional Feature:
FPU_ISSUE_WDOG_EN
- Defined: a counter is cleared on each state entry and runs in WAIT and DRAIN.
  - At WDOG_MAX cycles in WAIT: set err (sticky until reset), return rsp_result=32'hFFFFFFFF with rsp_flags=0, and go to RESP.
  - At WDOG_MAX cycles in DRAIN: set err and go to IDLE.
- Undefined: no counter; WAIT and DRAIN wait indefinitely; err is tied to 0.

Test Plan:
1. req0 add (op 0), opa=opb=32'h3F800000, rm=0 -> fpu_decode at T+1, fpu_execute at T+2, rsp_result=32'h40000000, rsp_id=0, then one fpu_flush pulse.
2. req1 compare-eq (op 8), opa=opb=32'h40400000 -> FSM waits on fpu_valid_cmp; rsp_cmp=1, rsp_id=1.
3. req0 and req1 valid in the same cycle, both persistent -> grants alternate 0,1,0,1 over four operations.
4. rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_result stable for all 10 cycles; fpu_flush only after the handshake.
5. reset_n=0 for 1 cycle while in WAIT -> all outputs 0 next cycle and no response; the next request completes normally.
6. With FPU_ISSUE_WDOG_EN and a stalled FPU model -> err=1 and rsp_result=32'hFFFFFFFF after 64 WAIT cycles.
